hazard_ctrl_unit: RTL and testbench

//  Central hazard/forwarding controller for the 5-stage pipeline; successor of the single-level forwarder.

---
 rtl/hazard_ctrl_unit_if.sv | 58 +++++
 rtl/hazard_ctrl_unit.sv | 168 ++++++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_unit_if.sv
// Hazard controller bundle: ID/EX/MEM/WB hazard inputs and
// the stall, flush, forwarding and status outputs.
interface hazard_ctrl_unit_if #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
);
    logic [REG_AW-1:0] id_rs1;
    logic [REG_AW-1:0] id_rs2;
    logic              id_rs1_used;
    logic              id_rs2_used;
    logic [REG_AW-1:0] ex_rd;
    logic              ex_regwrite;
    logic              ex_memread;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_regwrite;
    logic              mem_memacc;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_regwrite;
    logic              dmem_ready;
    logic              mc_start;
    logic              mc_done;
    logic              ex_br_taken;
    logic              id_jump;
    logic [1:0]        fwd_a;
    logic [1:0]        fwd_b;
    logic              pc_stall;
    logic              if_id_stall;
    logic              if_id_flush;
    logic              id_ex_bubble;
    logic              ex_mem_stall;
    logic              err_timeout;
    logic [CNT_W-1:0]  perf_stall_cnt;
    logic [CNT_W-1:0]  perf_flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rd, ex_regwrite, ex_memread,
        output mem_rd, mem_regwrite, mem_memacc,
        output wb_rd, wb_regwrite,
        output dmem_ready, mc_start, mc_done,
        output ex_br_taken, id_jump,
        input  fwd_a, fwd_b, pc_stall, if_id_stall,
        input  if_id_flush, id_ex_bubble, ex_mem_stall,
        input  err_timeout, perf_stall_cnt, perf_flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rd, ex_regwrite, ex_memread,
        input  mem_rd, mem_regwrite, mem_memacc,
        input  wb_rd, wb_regwrite,
        input  dmem_ready, mc_start, mc_done,
        input  ex_br_taken, id_jump,
        output fwd_a, fwd_b, pc_stall, if_id_stall,
        output if_id_flush, id_ex_bubble, ex_mem_stall,
        output err_timeout, perf_stall_cnt, perf_flush_cnt
    );
endinterface

// File: rtl/hazard_ctrl_unit.sv
// Central hazard controller: 3-source forwarding, load-use
// interlock, multi-cycle wait FSM, flush sequencing, watchdog.
module hazard_ctrl_unit #(
    parameter int REG_AW      = 5,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT     = 255,
    parameter int BR_FLUSH_EX = 1
) (
    input logic               clk,
    input logic               rst_n,
    hazard_ctrl_unit_if.slave hz_if
);
    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

    localparam logic [1:0] RUN      = 2'd0;
    localparam logic [1:0] MEM_WAIT = 2'd1;
    localparam logic [1:0] MC_WAIT  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             mc_pend_q, mc_pend_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic       run, mem_trig, mc_trig, mc_hold;
    logic       hold, free;
    logic       lu_a, lu_b, lu, br, lu_stall, jmp_flush;
    logic [1:0] fwd_a_raw, fwd_b_raw;
    logic       pc_stall_w, flush_w;

    function automatic logic [1:0] pick(
        input logic [REG_AW-1:0] rs,
        input logic              used,
        input logic [REG_AW-1:0] e_rd,
        input logic              e_we,
        input logic [REG_AW-1:0] m_rd,
        input logic              m_we,
        input logic [REG_AW-1:0] w_rd,
        input logic              w_we
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (used && rs != '0) begin
            if (e_we && e_rd == rs)
                sel = 2'b01;
            else if (m_we && m_rd == rs)
                sel = 2'b10;
            else if (w_we && w_rd == rs)
                sel = 2'b11;
        end
        return sel;
    endfunction

    assign fwd_a_raw = pick(hz_if.id_rs1, hz_if.id_rs1_used,
        hz_if.ex_rd, hz_if.ex_regwrite,
        hz_if.mem_rd, hz_if.mem_regwrite,
        hz_if.wb_rd, hz_if.wb_regwrite);
    assign fwd_b_raw = pick(hz_if.id_rs2, hz_if.id_rs2_used,
        hz_if.ex_rd, hz_if.ex_regwrite,
        hz_if.mem_rd, hz_if.mem_regwrite,
        hz_if.wb_rd, hz_if.wb_regwrite);

    assign run      = (state_q == RUN);
    assign mem_trig = run & hz_if.mem_memacc & ~hz_if.dmem_ready;
    assign mc_trig  = run & hz_if.mc_start & ~hz_if.mc_done;
    // a queued mul/div keeps the pipe frozen past the memory release
    assign mc_hold  = mc_pend_q & ~hz_if.mc_done;

    always_comb begin
        hold = 1'b0;
        unique case (state_q)
            RUN:      hold = mem_trig | mc_trig;
            MEM_WAIT: hold = ~hz_if.dmem_ready | mc_hold;
            MC_WAIT:  hold = ~hz_if.mc_done;
            default:  hold = 1'b0;
        endcase
    end

    assign free = run & ~hold;

    assign lu_a = free & hz_if.ex_memread
                & (hz_if.ex_rd != '0) & hz_if.id_rs1_used
                & (hz_if.id_rs1 == hz_if.ex_rd);
    assign lu_b = free & hz_if.ex_memread
                & (hz_if.ex_rd != '0) & hz_if.id_rs2_used
                & (hz_if.id_rs2 == hz_if.ex_rd);
    assign lu   = lu_a | lu_b;

    // a taken branch kills the dependent instruction, so no interlock
    assign br        = free & hz_if.ex_br_taken;
    assign lu_stall  = lu & ~br;
    assign jmp_flush = free & hz_if.id_jump & ~lu;

    assign pc_stall_w = hold | lu_stall;
    assign flush_w    = br | jmp_flush;

    assign hz_if.fwd_a        = lu_a ? 2'b00 : fwd_a_raw;
    assign hz_if.fwd_b        = lu_b ? 2'b00 : fwd_b_raw;
    assign hz_if.pc_stall     = pc_stall_w;
    assign hz_if.if_id_stall  = pc_stall_w;
    assign hz_if.if_id_flush  = flush_w;
    assign hz_if.id_ex_bubble = lu_stall
                              | (br & (BR_FLUSH_EX != 0));
    assign hz_if.ex_mem_stall = hold;
    assign hz_if.err_timeout    = err_q;
    assign hz_if.perf_stall_cnt = stall_cnt_q;
    assign hz_if.perf_flush_cnt = flush_cnt_q;

    always_comb begin
        state_d   = state_q;
        mc_pend_d = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_trig) begin
                    state_d   = MEM_WAIT;
                    mc_pend_d = mc_trig;
                end else if (mc_trig) begin
                    state_d = MC_WAIT;
                end
            end
            MEM_WAIT: begin
                mc_pend_d = mc_hold;
                if (hz_if.dmem_ready) begin
                    state_d   = mc_hold ? MC_WAIT : RUN;
                    mc_pend_d = 1'b0;
                end
            end
            MC_WAIT: begin
                if (hz_if.mc_done)
                    state_d = RUN;
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        wd_d  = '0;
        err_d = err_q;
        if (!run) begin
            wd_d  = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;
            err_d = err_q | (wd_q >= WD_LAST);
        end
    end

    assign stall_cnt_d = stall_cnt_q + CNT_W'(pc_stall_w);
    assign flush_cnt_d = flush_cnt_q + CNT_W'(flush_w);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= RUN;
            mc_pend_q   <= 1'b0;
            wd_q        <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            mc_pend_q   <= mc_pend_d;
            wd_q        <= wd_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Bench for hazard_ctrl_unit: directed scenarios plus random
// traffic against a behavioural reference model.
module tb_hazard_ctrl_unit;
    localparam int AW  = 5;
    localparam int CW  = 8;
    localparam int TO  = 4;
    localparam bit BRF = 1'b1;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    hazard_ctrl_unit_if #(.REG_AW(AW), .CNT_W(CW)) hz ();

    hazard_ctrl_unit #(
        .REG_AW(AW), .CNT_W(CW),
        .TIMEOUT(TO), .BR_FLUSH_EX(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hz_if(hz)
    );

    int checks = 0;
    int errors = 0;

    // model: which wait the pipe is in, queued mul/div, watchdog
    bit m_mem, m_mc, m_pend, m_err;
    int m_len, m_scnt, m_fcnt;
    int e_fa, e_fb;
    bit e_pc, e_fl, e_bub, e_ems;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic int pick(input logic [AW-1:0] rs,
                                input logic used);
        logic [AW-1:0] rd [3];
        bit            we [3];
        rd[0] = hz.ex_rd;  we[0] = hz.ex_regwrite;
        rd[1] = hz.mem_rd; we[1] = hz.mem_regwrite;
        rd[2] = hz.wb_rd;  we[2] = hz.wb_regwrite;
        if (!used || rs == 0) return 0;
        for (int i = 0; i < 3; i++)
            if (we[i] && rd[i] == rs) return i + 1;
        return 0;
    endfunction

    task automatic model_eval();
        bit run, tm, tc, hold, free, l1, l2, br;
        run = !m_mem && !m_mc;
        tm  = run && hz.mem_memacc && !hz.dmem_ready;
        tc  = run && hz.mc_start && !hz.mc_done;
        if (m_mem)
            hold = !hz.dmem_ready || (m_pend && !hz.mc_done);
        else if (m_mc)
            hold = !hz.mc_done;
        else
            hold = tm || tc;
        free = run && !hold;
        l1 = free && hz.ex_memread && hz.ex_rd != 0
             && hz.id_rs1_used && hz.id_rs1 == hz.ex_rd;
        l2 = free && hz.ex_memread && hz.ex_rd != 0
             && hz.id_rs2_used && hz.id_rs2 == hz.ex_rd;
        br   = free && hz.ex_br_taken;
        e_fa = l1 ? 0 : pick(hz.id_rs1, hz.id_rs1_used);
        e_fb = l2 ? 0 : pick(hz.id_rs2, hz.id_rs2_used);
        e_pc  = hold || ((l1 || l2) && !br);
        e_ems = hold;
        e_fl  = br || (free && hz.id_jump && !(l1 || l2));
        e_bub = (br && BRF) || ((l1 || l2) && !br);
    endtask

    task automatic model_step();
        bit run;
        run = !m_mem && !m_mc;
        if (!rst_n) begin
            m_mem = 0; m_mc = 0; m_pend = 0; m_err = 0;
            m_len = 0; m_scnt = 0; m_fcnt = 0;
        end else begin
            m_scnt = (m_scnt + int'(e_pc)) % (1 << CW);
            m_fcnt = (m_fcnt + int'(e_fl)) % (1 << CW);
            if (!run) begin
                m_len++;
                if (m_len >= TO) m_err = 1;
            end else begin
                m_len = 0;
            end
            if (m_mem) begin
                if (hz.mc_done) m_pend = 0;
                if (hz.dmem_ready) begin
                    m_mem = 0; m_mc = m_pend; m_pend = 0;
                end
            end else if (m_mc) begin
                if (hz.mc_done) m_mc = 0;
            end else if (hz.mem_memacc && !hz.dmem_ready) begin
                m_mem  = 1;
                m_pend = hz.mc_start && !hz.mc_done;
            end else if (hz.mc_start && !hz.mc_done) begin
                m_mc = 1;
            end
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        model_eval();
        check("fwd_a", 32'(hz.fwd_a), 32'(e_fa));
        check("fwd_b", 32'(hz.fwd_b), 32'(e_fb));
        check("pc_stall", 32'(hz.pc_stall), 32'(e_pc));
        check("if_id_stall", 32'(hz.if_id_stall), 32'(e_pc));
        check("if_id_flush", 32'(hz.if_id_flush), 32'(e_fl));
        check("id_ex_bubble", 32'(hz.id_ex_bubble), 32'(e_bub));
        check("ex_mem_stall", 32'(hz.ex_mem_stall), 32'(e_ems));
        check("err_timeout", 32'(hz.err_timeout), 32'(m_err));
        check("stall_cnt", 32'(hz.perf_stall_cnt), 32'(m_scnt));
        check("flush_cnt", 32'(hz.perf_flush_cnt), 32'(m_fcnt));
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic clear_in();
        hz.id_rs1 = '0; hz.id_rs2 = '0;
        hz.id_rs1_used = 0; hz.id_rs2_used = 0;
        hz.ex_rd = '0; hz.ex_regwrite = 0; hz.ex_memread = 0;
        hz.mem_rd = '0; hz.mem_regwrite = 0; hz.mem_memacc = 0;
        hz.wb_rd = '0; hz.wb_regwrite = 0;
        hz.dmem_ready = 0; hz.mc_start = 0; hz.mc_done = 0;
        hz.ex_br_taken = 0; hz.id_jump = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        cycle();
        rst_n = 1;
    endtask

    initial begin
        clear_in();
        rst_n = 0;
        m_mem = 0; m_mc = 0; m_pend = 0; m_err = 0;
        m_len = 0; m_scnt = 0; m_fcnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        check("rst_pc_stall", 32'(hz.pc_stall), 0);
        check("rst_flush", 32'(hz.if_id_flush), 0);
        check("rst_cnt", 32'(hz.perf_stall_cnt), 0);
        check("rst_err", 32'(hz.err_timeout), 0);
        cycle();

        // forwarding priority EX > MEM > WB, x0 never forwards
        hz.ex_rd = 5;  hz.ex_regwrite = 1;
        hz.mem_rd = 5; hz.mem_regwrite = 1;
        hz.wb_rd = 5;  hz.wb_regwrite = 1;
        hz.id_rs1 = 5; hz.id_rs2 = 5;
        hz.id_rs1_used = 1; hz.id_rs2_used = 1;
        #1;
        check("fwd_ex_a", 32'(hz.fwd_a), 1);
        check("fwd_ex_b", 32'(hz.fwd_b), 1);
        cycle();
        hz.ex_regwrite = 0;
        #1;
        check("fwd_mem", 32'(hz.fwd_a), 2);
        cycle();
        hz.mem_regwrite = 0;
        #1;
        check("fwd_wb", 32'(hz.fwd_b), 3);
        cycle();
        hz.id_rs1 = 0; hz.id_rs2 = 0;
        hz.ex_rd = 0; hz.mem_rd = 0; hz.wb_rd = 0;
        hz.ex_regwrite = 1; hz.mem_regwrite = 1;
        #1;
        check("fwd_x0", 32'(hz.fwd_a), 0);
        cycle();

        // load-use on rs2, then the load moves to MEM
        clear_in();
        hz.ex_rd = 7; hz.ex_regwrite = 1; hz.ex_memread = 1;
        hz.id_rs1 = 1; hz.id_rs1_used = 1;
        hz.id_rs2 = 7; hz.id_rs2_used = 1;
        #1;
        check("lu_pc_stall", 32'(hz.pc_stall), 1);
        check("lu_bubble", 32'(hz.id_ex_bubble), 1);
        check("lu_fwd_b", 32'(hz.fwd_b), 0);
        cycle();
        hz.ex_rd = 0; hz.ex_regwrite = 0; hz.ex_memread = 0;
        hz.mem_rd = 7; hz.mem_regwrite = 1;
        hz.mem_memacc = 1; hz.dmem_ready = 1;
        #1;
        check("lu_after_stall", 32'(hz.pc_stall), 0);
        check("lu_after_fwd", 32'(hz.fwd_b), 2);
        cycle();

        // memory wait of 3 cycles
        clear_in();
        do_reset();
        hz.mem_memacc = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("memw_stall", 32'(hz.ex_mem_stall), 1);
            cycle();
        end
        hz.dmem_ready = 1;
        #1;
        check("memw_release", 32'(hz.ex_mem_stall), 0);
        cycle();
        clear_in();
        #1;
        check("memw_cnt", 32'(hz.perf_stall_cnt), 3);
        cycle();

        // mul/div wait with a branch arriving meanwhile
        hz.mc_start = 1; hz.ex_br_taken = 1;
        #1;
        check("mc_trig_flush", 32'(hz.if_id_flush), 0);
        cycle();
        hz.mc_start = 0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("mc_wait_flush", 32'(hz.if_id_flush), 0);
            check("mc_wait_stall", 32'(hz.pc_stall), 1);
            cycle();
        end
        hz.mc_done = 1; hz.ex_br_taken = 0;
        #1;
        check("mc_release", 32'(hz.pc_stall), 0);
        cycle();
        hz.mc_done = 0; hz.ex_br_taken = 1;
        #1;
        check("mc_run_flush", 32'(hz.if_id_flush), 1);
        cycle();

        // watchdog, then reset in the middle of a wait
        clear_in();
        do_reset();
        hz.mem_memacc = 1;
        repeat (5) cycle();
        #1;
        check("wd_set", 32'(hz.err_timeout), 1);
        hz.dmem_ready = 1;
        cycle();
        clear_in();
        cycle();
        #1;
        check("wd_sticky", 32'(hz.err_timeout), 1);
        hz.mem_memacc = 1;
        repeat (2) cycle();
        rst_n = 0;
        cycle();
        rst_n = 1;
        clear_in();
        #1;
        check("rw_stall", 32'(hz.pc_stall), 0);
        check("rw_err", 32'(hz.err_timeout), 0);
        check("rw_cnt", 32'(hz.perf_stall_cnt), 0);
        cycle();

        // branch beats a pending load-use
        hz.ex_rd = 7; hz.ex_regwrite = 1; hz.ex_memread = 1;
        hz.id_rs2 = 7; hz.id_rs2_used = 1;
        hz.ex_br_taken = 1;
        #1;
        check("br_lu_flush", 32'(hz.if_id_flush), 1);
        check("br_lu_bubble", 32'(hz.id_ex_bubble), 1);
        check("br_lu_stall", 32'(hz.pc_stall), 0);
        cycle();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            hz.id_rs1 = AW'($urandom_range(0, 3));
            hz.id_rs2 = AW'($urandom_range(0, 3));
            hz.id_rs1_used = ($urandom_range(0, 3) != 0);
            hz.id_rs2_used = ($urandom_range(0, 3) != 0);
            hz.ex_rd = AW'($urandom_range(0, 3));
            hz.ex_regwrite = $urandom_range(0, 1) == 1;
            hz.ex_memread = ($urandom_range(0, 3) == 0);
            hz.mem_rd = AW'($urandom_range(0, 3));
            hz.mem_regwrite = $urandom_range(0, 1) == 1;
            hz.mem_memacc = ($urandom_range(0, 2) == 0);
            hz.wb_rd = AW'($urandom_range(0, 3));
            hz.wb_regwrite = $urandom_range(0, 1) == 1;
            hz.dmem_ready = ($urandom_range(0, 9) < 4);
            hz.mc_start = ($urandom_range(0, 5) == 0);
            hz.mc_done = ($urandom_range(0, 2) == 0);
            hz.ex_br_taken = ($urandom_range(0, 7) == 0);
            hz.id_jump = ($urandom_range(0, 7) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
